bus_demux_1to2_8b: RTL and testbench

- Registered 1-to-2 bus demultiplexer for the 8-bit datapath. It is the distributing counterpart of the 2-to-1 bus selector.
- Takes one valid/ready source stream and steers each beat to destination 0 or 1 according to a per-beat select bit.
- Each destination has a one-entry output register, so timing is cut between the producer (ALU/bus) and its consumers (register file ports, output latch).

---
 rtl/bus_demux_1to2_8b.sv | 91 +++++++++
 tb/tb_bus_demux_1to2_8b.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_demux_1to2_8b.sv
// Registered 1-to-2 valid/ready demultiplexer with a one-entry output register per destination.
// Define DEMUX_BROADCAST_EN to add in_bcast, which writes both destinations atomically.
module bus_demux_1to2_8b #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
`ifdef DEMUX_BROADCAST_EN
  input  logic             in_bcast,
`endif
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready
);

  logic [WIDTH-1:0] out0_data_q, out0_data_d;
  logic [WIDTH-1:0] out1_data_q, out1_data_d;
  logic             out0_valid_q, out0_valid_d;
  logic             out1_valid_q, out1_valid_d;

  logic accept0, accept1, bcast, xfer, load0, load1;

`ifdef DEMUX_BROADCAST_EN
  assign bcast = in_bcast;
`else
  assign bcast = 1'b0;
`endif

  always_comb begin
    // A slot can take a beat when empty or when its current beat leaves this cycle.
    accept0 = ~out0_valid_q | out0_ready;
    accept1 = ~out1_valid_q | out1_ready;

    if (bcast) begin
      in_ready = accept0 & accept1;
    end else if (in_sel) begin
      in_ready = accept1;
    end else begin
      in_ready = accept0;
    end

    xfer  = in_valid & in_ready;
    load0 = xfer & (bcast | ~in_sel);
    load1 = xfer & (bcast | in_sel);

    out0_data_d  = out0_data_q;
    out0_valid_d = out0_valid_q;
    if (load0) begin
      out0_data_d  = in_data;
      out0_valid_d = 1'b1;
    end else if (out0_ready) begin
      out0_valid_d = 1'b0;
    end

    out1_data_d  = out1_data_q;
    out1_valid_d = out1_valid_q;
    if (load1) begin
      out1_data_d  = in_data;
      out1_valid_d = 1'b1;
    end else if (out1_ready) begin
      out1_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out0_data_q  <= '0;
      out1_data_q  <= '0;
      out0_valid_q <= 1'b0;
      out1_valid_q <= 1'b0;
    end else begin
      out0_data_q  <= out0_data_d;
      out1_data_q  <= out1_data_d;
      out0_valid_q <= out0_valid_d;
      out1_valid_q <= out1_valid_d;
    end
  end

  assign out0_data  = out0_data_q;
  assign out0_valid = out0_valid_q;
  assign out1_data  = out1_data_q;
  assign out1_valid = out1_valid_q;

endmodule

// File: tb/tb_bus_demux_1to2_8b.sv
// Directed self-checking bench for bus_demux_1to2_8b; inputs change and outputs are sampled on
// the falling clock edge. The broadcast scenario runs only when DEMUX_BROADCAST_EN is defined.
module tb_bus_demux_1to2_8b;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_sel;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out0_data;
  logic       out0_valid;
  logic       out0_ready;
  logic [7:0] out1_data;
  logic       out1_valid;
  logic       out1_ready;
`ifdef DEMUX_BROADCAST_EN
  logic       in_bcast;
`endif

  int total;
  int bad;
  logic [7:0] sb1[$];

  bus_demux_1to2_8b #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
`ifdef DEMUX_BROADCAST_EN
    .in_bcast  (in_bcast),
`endif
    .in_ready  (in_ready),
    .out0_data (out0_data),
    .out0_valid(out0_valid),
    .out0_ready(out0_ready),
    .out1_data (out1_data),
    .out1_valid(out1_valid),
    .out1_ready(out1_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every beat consumed from destination 1.
  always @(posedge clk) begin
    if (rst_n && out1_valid && out1_ready) sb1.push_back(out1_data);
  end

  task automatic drive(input logic [7:0] d, input logic s, input logic v,
                       input logic r0, input logic r1);
    in_data    = d;
    in_sel     = s;
    in_valid   = v;
    out0_ready = r0;
    out1_ready = r1;
  endtask

  task automatic test_reset();
    // Fill both slots, then pull reset in the middle of a cycle.
    @(negedge clk);
    drive(8'h5A, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    drive(8'h77, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (out0_valid !== 1'b1 || out1_valid !== 1'b1) begin
      bad++;
      $display("FAIL reset_prefill: got v0=%b v1=%b want 1 1", out0_valid, out1_valid);
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (out0_valid !== 1'b0 || out1_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_valid: got v0=%b v1=%b want 0 0", out0_valid, out1_valid);
    end
    total++;
    if (out0_data !== 8'h00 || out1_data !== 8'h00) begin
      bad++;
      $display("FAIL reset_data: got d0=%h d1=%h want 00 00", out0_data, out1_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_single_route();
    @(negedge clk);
    drive(8'h5A, 1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL single_in_ready: got %b want 1", in_ready);
    end
    @(negedge clk);
    drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (out0_valid !== 1'b1 || out0_data !== 8'h5A || out1_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_load: got v0=%b d0=%h v1=%b want 1 5a 0",
               out0_valid, out0_data, out1_valid);
    end
    @(negedge clk);
    total++;
    if (out0_valid !== 1'b1 || out0_data !== 8'h5A) begin
      bad++;
      $display("FAIL single_hold: got v0=%b d0=%h want 1 5a", out0_valid, out0_data);
    end
    out0_ready = 1'b1;
    @(negedge clk);
    out0_ready = 1'b0;
    total++;
    if (out0_valid !== 1'b0 || out0_data !== 8'h5A) begin
      bad++;
      $display("FAIL single_drain: got v0=%b d0=%h want 0 5a", out0_valid, out0_data);
    end
  endtask

  task automatic test_stream();
    logic       ps;
    logic [7:0] pd;
    for (int i = 1; i <= 17; i++) begin
      @(negedge clk);
      if (i > 1) begin
        pd = 8'(i - 1);
        ps = ((i - 1) % 2) == 0;
        total++;
        if (ps == 1'b0 && (out0_valid !== 1'b1 || out0_data !== pd || out1_valid !== 1'b0)) begin
          bad++;
          $display("FAIL stream_out0 beat %0d: got v0=%b d0=%h v1=%b want 1 %h 0",
                   i - 1, out0_valid, out0_data, out1_valid, pd);
        end else if (ps == 1'b1 &&
                     (out1_valid !== 1'b1 || out1_data !== pd || out0_valid !== 1'b0)) begin
          bad++;
          $display("FAIL stream_out1 beat %0d: got v1=%b d1=%h v0=%b want 1 %h 0",
                   i - 1, out1_valid, out1_data, out0_valid, pd);
        end
      end
      if (i <= 16) begin
        drive(8'(i), (i % 2) == 0, 1'b1, 1'b1, 1'b1);
        #1;
        total++;
        if (in_ready !== 1'b1) begin
          bad++;
          $display("FAIL stream_in_ready beat %0d: got %b want 1", i, in_ready);
        end
      end else begin
        drive(8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
      end
    end
    @(negedge clk);
    drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    drive(8'hAA, 1'b0, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    drive(8'h33, 1'b0, 1'b1, 1'b0, 1'b1);
    #1;
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL bp_blocked_ready: got %b want 0", in_ready);
    end
    @(negedge clk);
    total++;
    if (out0_valid !== 1'b1 || out0_data !== 8'hAA) begin
      bad++;
      $display("FAIL bp_out0_held: got v0=%b d0=%h want 1 aa", out0_valid, out0_data);
    end
    drive(8'h44, 1'b1, 1'b1, 1'b0, 1'b0);
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_other_ready: got %b want 1", in_ready);
    end
    @(negedge clk);
    drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (out1_valid !== 1'b1 || out1_data !== 8'h44 || out0_valid !== 1'b1 ||
        out0_data !== 8'hAA) begin
      bad++;
      $display("FAIL bp_isolation: got v1=%b d1=%h v0=%b d0=%h want 1 44 1 aa",
               out1_valid, out1_data, out0_valid, out0_data);
    end
    drive(8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_drain_load();
    int n11;
    sb1.delete();
    @(negedge clk);
    drive(8'h11, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    drive(8'h22, 1'b1, 1'b1, 1'b0, 1'b1);
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL dl_in_ready: got %b want 1", in_ready);
    end
    @(negedge clk);
    drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (out1_valid !== 1'b1 || out1_data !== 8'h22) begin
      bad++;
      $display("FAIL dl_reload: got v1=%b d1=%h want 1 22", out1_valid, out1_data);
    end
    out1_ready = 1'b1;
    @(negedge clk);
    out1_ready = 1'b0;
    n11 = 0;
    foreach (sb1[k]) if (sb1[k] == 8'h11) n11++;
    total++;
    if (n11 != 1 || sb1.size() != 2 || out1_valid !== 1'b0) begin
      bad++;
      $display("FAIL dl_scoreboard: got n11=%0d size=%0d v1=%b want 1 2 0",
               n11, sb1.size(), out1_valid);
    end
  endtask

`ifdef DEMUX_BROADCAST_EN
  task automatic test_broadcast();
    @(negedge clk);
    drive(8'h99, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    drive(8'h7E, 1'b0, 1'b1, 1'b0, 1'b0);
    in_bcast = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL bc_blocked_ready: got %b want 0", in_ready);
    end
    @(negedge clk);
    total++;
    if (out0_valid !== 1'b0 || out1_valid !== 1'b1 || out1_data !== 8'h99) begin
      bad++;
      $display("FAIL bc_no_partial: got v0=%b v1=%b d1=%h want 0 1 99",
               out0_valid, out1_valid, out1_data);
    end
    out1_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL bc_ready: got %b want 1", in_ready);
    end
    @(negedge clk);
    in_bcast = 1'b0;
    drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (out0_valid !== 1'b1 || out0_data !== 8'h7E || out1_valid !== 1'b1 ||
        out1_data !== 8'h7E) begin
      bad++;
      $display("FAIL bc_both: got v0=%b d0=%h v1=%b d1=%h want 1 7e 1 7e",
               out0_valid, out0_data, out1_valid, out1_data);
    end
    drive(8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
`ifdef DEMUX_BROADCAST_EN
    in_bcast = 1'b0;
`endif
    drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_single_route();
    test_stream();
    test_backpressure();
    test_drain_load();
`ifdef DEMUX_BROADCAST_EN
    test_broadcast();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
